// File: rtl/mod5_frame_tx_if.sv
// rtl/mod5_frame_tx_if.sv - parallel-in / serial-out handshake bundle for mod5_frame_tx
// Ports (signals carried by the interface):
//   data_in[DATA_W], data_valid, data_ready : parallel word handshake (source -> block)
//   ser_out, ser_valid, ser_ready           : serial bit stream handshake (block -> link)
//   frame_start, frame_end                  : first data bit / last check bit markers
//   residue[3]                              : running payload residue mod 5
// Modports: master = source/link side (testbench), slave = the transmitter.
interface mod5_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_ready;
  logic              frame_start;
  logic              frame_end;
  logic [2:0]        residue;

  modport master (
    output data_in, data_valid, ser_ready,
    input  data_ready, ser_out, ser_valid, frame_start, frame_end, residue
  );

  modport slave (
    input  data_in, data_valid, ser_ready,
    output data_ready, ser_out, ser_valid, frame_start, frame_end, residue
  );
endinterface

// File: rtl/mod5_frame_tx.sv
// rtl/mod5_frame_tx.sv - MSB-first serial framer appending 3 check bits so frame value is 0 mod 5
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : mod5_frame_tx_if.slave (data_in/data_valid/data_ready parallel side,
//           ser_out/ser_valid/ser_ready serial side, frame_start, frame_end, residue)
// A frame is DATA_W payload bits followed by c[2],c[1],c[0]; outputs advance only on
// beats (ser_valid && ser_ready) and hold otherwise.
module mod5_frame_tx #(
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  mod5_frame_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Counter holds "bits remaining after the current one": up to DATA_W-1 in DATA, 2 in CHECK.
  localparam int CW = $clog2((DATA_W > 3) ? DATA_W : 3);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic [2:0]        residue_q, residue_d;
  logic [1:0]        check_q, check_d;   // c[2] goes straight to ser_out, only c[1:0] wait

  logic       last_check;
  logic       accept;
  logic       beat;
  logic [3:0] res_dbl;
  logic [2:0] res_nxt;
  logic [2:0] check_nxt;

  assign bus.ser_valid   = (state_q != IDLE);
  assign last_check      = (state_q == CHECK) && (cnt_q == '0);
  // Ready on the final check beat lets a new word follow with no idle bit.
  assign bus.data_ready  = (state_q == IDLE) || (last_check && bus.ser_ready);
  assign accept          = bus.data_valid && bus.data_ready;
  assign beat            = bus.ser_valid && bus.ser_ready;

  assign bus.ser_out     = ser_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.residue     = residue_q;

  // 2*r+b never exceeds 9, so one conditional subtract reduces it mod 5.
  assign res_dbl = {residue_q, 1'b0} + {3'b000, ser_out_q};
  assign res_nxt = (res_dbl >= 4'd5) ? 3'(res_dbl - 4'd5) : res_dbl[2:0];

  // Check = 2*r mod 5 expressed as the 3-bit codes the link expects.
  always_comb begin
    check_nxt = 3'b000;
    case (res_nxt)
      3'd0:    check_nxt = 3'b000;
      3'd1:    check_nxt = 3'b010;
      3'd2:    check_nxt = 3'b100;
      3'd3:    check_nxt = 3'b110;
      3'd4:    check_nxt = 3'b011;
      default: check_nxt = 3'b000;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    ser_out_d     = ser_out_q;
    frame_start_d = frame_start_q;
    frame_end_d   = frame_end_q;
    residue_d     = residue_q;
    check_d       = check_q;

    case (state_q)
      DATA: begin
        if (beat) begin
          frame_start_d = 1'b0;
          residue_d     = res_nxt;
          if (cnt_q == '0) begin
            state_d   = CHECK;
            ser_out_d = check_nxt[2];
            check_d   = check_nxt[1:0];
            cnt_d     = CW'(2);
          end else begin
            shift_d   = shift_q << 1;
            ser_out_d = shift_d[DATA_W-1];
            cnt_d     = cnt_q - 1'b1;
          end
        end
      end
      CHECK: begin
        if (beat) begin
          if (cnt_q == CW'(2)) begin
            ser_out_d = check_q[1];
            cnt_d     = CW'(1);
          end else if (cnt_q == CW'(1)) begin
            ser_out_d   = check_q[0];
            frame_end_d = 1'b1;
            cnt_d       = '0;
          end else begin
            state_d     = IDLE;
            ser_out_d   = 1'b0;
            frame_end_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Accept overrides the end-of-frame return to IDLE for back-to-back frames.
    if (accept) begin
      state_d       = DATA;
      shift_d       = bus.data_in;
      ser_out_d     = bus.data_in[DATA_W-1];
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
      residue_d     = 3'd0;
      cnt_d         = CW'(DATA_W - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      residue_q     <= 3'd0;
      check_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      residue_q     <= residue_d;
      check_q       <= check_d;
    end
  end

endmodule

// File: tb/tb_mod5_frame_tx.sv
// tb/tb_mod5_frame_tx.sv - randomized self-checking bench for mod5_frame_tx
module tb_mod5_frame_tx;
  localparam int W = 8;

  typedef struct {
    logic       b;
    logic       fs;
    logic       fe;
    logic [2:0] res;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod5_frame_tx_if #(.DATA_W(W)) ifc ();
  mod5_frame_tx #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   rand_rdy = 1'b0;
  int   beats = 0;
  int   det = 0;
  int   chk_tab[5] = '{0, 2, 4, 6, 3};
  ent_t exp_q[$];
  ent_t mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame from plain arithmetic: payload bits, prefix residues, table check bits.
  function automatic void push_frame(input int w);
    ent_t e;
    int   r;
    for (int i = W - 1; i >= 0; i--) begin
      e.b   = 1'((w >> i) & 1);
      e.fs  = (i == W - 1);
      e.fe  = 1'b0;
      e.res = 3'((w >> (i + 1)) % 5);
      exp_q.push_back(e);
    end
    r = w % 5;
    for (int i = 2; i >= 0; i--) begin
      e.b   = 1'((chk_tab[r] >> i) & 1);
      e.fs  = 1'b0;
      e.fe  = (i == 0);
      e.res = 3'(r);
      exp_q.push_back(e);
    end
  endfunction

  initial begin
    ifc.ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 ifc.ser_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare presented bit with scoreboard head; pop on beat; run a mod-5 detector.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check_val("idle_valid", 32'(ifc.ser_valid), 32'd0);
        check_val("idle_ready", 32'(ifc.data_ready), 32'd1);
      end else begin
        mon_e = exp_q[0];
        check_val("valid", 32'(ifc.ser_valid), 32'd1);
        check_val("bit", 32'(ifc.ser_out), 32'(mon_e.b));
        check_val("fstart", 32'(ifc.frame_start), 32'(mon_e.fs));
        check_val("fend", 32'(ifc.frame_end), 32'(mon_e.fe));
        check_val("residue", 32'(ifc.residue), 32'(mon_e.res));
        check_val("ready", 32'(ifc.data_ready), 32'(mon_e.fe && ifc.ser_ready));
        if (ifc.ser_ready && rst_n) begin
          det = mon_e.fs ? int'(ifc.ser_out) : (2 * det + int'(ifc.ser_out)) % 5;
          if (mon_e.fe) check_val("det_zero", 32'(det), 32'd0);
          void'(exp_q.pop_front());
          beats++;
        end
      end
      if (!rst_n) begin
        exp_q.delete();
        det = 0;
      end else if (ifc.data_valid && ifc.data_ready) begin
        push_frame(int'(ifc.data_in));
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input logic [W-1:0] w, input bit hold);
    bit ok = 1'b0;
    ifc.data_in    = w;
    ifc.data_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ifc.data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (!hold) begin
      ifc.data_valid = 1'b0;
      ifc.data_in    = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ifc.ser_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    bit ok;
    ifc.data_in    = '0;
    ifc.data_valid = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 32'(ifc.ser_valid), 32'd0);
    check_val("rst_ready", 32'(ifc.data_ready), 32'd1);
    check_val("rst_out", 32'(ifc.ser_out), 32'd0);
    check_val("rst_fs", 32'(ifc.frame_start), 32'd0);
    check_val("rst_fe", 32'(ifc.frame_end), 32'd0);
    check_val("rst_res", 32'(ifc.residue), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    send(8'h05, 1'b0);
    wait_idle();
    send(8'h01, 1'b0); wait_idle();
    send(8'h07, 1'b0); wait_idle();
    send(8'h03, 1'b0); wait_idle();
    send(8'h04, 1'b0); wait_idle();

    send(8'hFF, 1'b1);
    send(8'h02, 1'b0);
    wait_idle();

    rand_rdy = 1'b1;
    send(8'h0B, 1'b0);
    wait_idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;

    b0 = beats;
    send(8'hA7, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beats == b0 + 4) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("beat_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_valid", 32'(ifc.ser_valid), 32'd0);
    check_val("abort_ready", 32'(ifc.data_ready), 32'd1);
    check_val("abort_res", 32'(ifc.residue), 32'd0);
    @(posedge clk);
    #1;
    send(8'h05, 1'b0);
    wait_idle();

    rand_rdy = 1'b1;
    for (int w = 0; w < 256; w++) begin
      send(W'(w), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    check_val("q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
